// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
// Holds the default frame marker and memory depth, and the frame FSM state type.
// The word index width comes from a helper so the top can re-derive it when the
// depth parameter is overridden.
package loader_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned MAX_WORDS_DEF = 14;

    // Index width for a memory of n words (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned WORD_IDX_W = idx_width(MAX_WORDS_DEF);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StWrite,
        StCheck,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver.
// Ports:
//   CLK       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   rx        in   asynchronous serial input, idle high
//   rx_valid  out  one-cycle pulse when a byte (and its stop bit) has been sampled
//   rx_data   out  received byte, valid with rx_valid
//   rx_ferr   out  stop bit was sampled low, valid with rx_valid
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e        state_q;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= RxIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rx_valid  <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    // Falling edge only, so a line stuck low after a bad stop bit
                    // cannot retrigger.
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RxStart;
                        cnt_q   <= '0;
                    end
                end
                RxStart: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q <= rx_sync_q ? RxIdle : RxData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RxStop;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q    <= '0;
                        state_q  <= RxIdle;
                        rx_valid <= 1'b1;
                        rx_data  <= shift_q;
                        rx_ferr  <= !rx_sync_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Loads instruction memory from a framed UART byte stream.
// Frame: SYNC_BYTE, N, 4*N data bytes (little-endian words), XOR of the data bytes.
// Ports:
//   CLK          in   system clock, rising edge
//   rst_n        in   synchronous active-low reset
//   uart_rx      in   serial input, idle high
//   imem_we      out  one-cycle write strobe
//   imem_addr    out  word-aligned byte address, held until the next word
//   imem_wd      out  write data, held until the next word
//   prog_active  out  high while a frame is in progress (core held in reset)
//   load_done    out  sticky: last frame completed with good checksum
//   load_err     out  sticky: last frame was rejected
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned MAX_WORDS    = MAX_WORDS_DEF,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        prog_active,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned IDX_W = idx_width(MAX_WORDS);
    localparam logic [7:0]  MAX_N = 8'(MAX_WORDS);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .rx      (uart_rx),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    loader_state_e    state_q;
    logic [IDX_W-1:0] word_idx_q;
    logic [1:0]       byte_idx_q;
    logic [7:0]       chk_q;
    logic [7:0]       count_q;
    logic [31:0]      word_q;   // assembly buffer, keeps imem_wd stable meanwhile

    logic       rx_ok, rx_bad;
    logic [7:0] words_written;

    assign rx_ok         = rx_valid && !rx_ferr;
    assign rx_bad        = rx_valid && rx_ferr;
    assign words_written = 8'(word_idx_q) + 8'd1;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            chk_q       <= '0;
            count_q     <= '0;
            word_q      <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wd     <= '0;
            prog_active <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_ok && rx_data == SYNC_BYTE) begin
                        prog_active <= 1'b1;
                        load_done   <= 1'b0;
                        load_err    <= 1'b0;
                        word_idx_q  <= '0;
                        byte_idx_q  <= '0;
                        chk_q       <= '0;
                        state_q     <= StCount;
                    end
                end
                StCount: begin
                    if (rx_bad) begin
                        state_q <= StErr;
                    end else if (rx_ok) begin
                        count_q <= rx_data;
                        state_q <= (rx_data == 8'd0 || rx_data > MAX_N) ? StErr : StData;
                    end
                end
                StData: begin
                    if (rx_bad) begin
                        state_q <= StErr;
                    end else if (rx_ok) begin
                        word_q[8*byte_idx_q +: 8] <= rx_data;
                        chk_q      <= chk_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 1'b1;
                        if (byte_idx_q == 2'd3) begin
                            state_q <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= 32'({word_idx_q, 2'b00});
                    imem_wd    <= word_q;
                    word_idx_q <= word_idx_q + 1'b1;
                    byte_idx_q <= '0;
                    state_q    <= (words_written == count_q) ? StCheck : StData;
                end
                StCheck: begin
                    if (rx_bad) begin
                        state_q <= StErr;
                    end else if (rx_ok) begin
                        state_q <= (rx_data == chk_q) ? StDone : StErr;
                    end
                end
                StDone: begin
                    load_done   <= 1'b1;
                    prog_active <= 1'b0;
                    state_q     <= StIdle;
                end
                StErr: begin
                    load_err    <= 1'b1;
                    prog_active <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
module tb_uart_imem_loader;

    localparam int unsigned CPB  = 16;
    localparam int unsigned MAXW = 14;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        prog_active;
    logic        load_done;
    logic        load_err;

    always #5 CLK = ~CLK;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .prog_active(prog_active),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    wr_t        exp_wr[$];
    logic [1:0] exp_st[$];   // {load_done, load_err} at end of frame
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model: decide from the bytes actually delivered which writes and
    // which final status the frame must produce.
    task automatic model(input bq_t fr, input int ferr_at, input int abort_at);
        int         lim = fr.size();
        bit         ferr = 1'b0;
        int         n;
        logic [7:0] x;
        wr_t        w;
        if (ferr_at >= 0 && ferr_at < lim) begin
            lim  = ferr_at;
            ferr = 1'b1;
        end
        if (abort_at >= 0 && abort_at < lim) begin
            lim  = abort_at;
            ferr = 1'b0;
        end
        if (lim < 1) return;
        if (lim < 2) begin
            if (ferr) exp_st.push_back(2'b01);
            return;
        end
        n = int'(fr[1]);
        if (n == 0 || n > MAXW) begin
            exp_st.push_back(2'b01);
            return;
        end
        for (int k = 0; k < n; k++) begin
            if (2 + 4 * k + 4 <= lim) begin
                w.addr = 32'(k * 4);
                w.wd   = {fr[2+4*k+3], fr[2+4*k+2], fr[2+4*k+1], fr[2+4*k]};
                exp_wr.push_back(w);
            end
        end
        if (lim >= 2 + 4 * n + 1) begin
            x = 8'h00;
            for (int k = 0; k < 4 * n; k++) x ^= fr[2+k];
            exp_st.push_back((fr[2+4*n] == x) ? 2'b10 : 2'b01);
        end else if (ferr) begin
            exp_st.push_back(2'b01);
        end
    endtask

    task automatic build_frame(input logic [31:0] words[$], input bit flip, output bq_t fr);
        logic [7:0] x = 8'h00;
        logic [31:0] wv;
        fr = {};
        fr.push_back(8'hA5);
        fr.push_back(8'(words.size()));
        for (int i = 0; i < words.size(); i++) begin
            wv = words[i];
            for (int b = 0; b < 4; b++) begin
                fr.push_back(wv[8*b +: 8]);
                x ^= wv[8*b +: 8];
            end
        end
        fr.push_back(flip ? ~x : x);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge CLK);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge CLK);
        if (!stop_ok) begin
            uart_rx = 1'b1;
            repeat (2 * CPB) @(negedge CLK);
        end
    endtask

    task automatic run_frame(input bq_t fr, input int ferr_at, input int abort_at, input bit gaps);
        model(fr, ferr_at, abort_at);
        for (int i = 0; i < fr.size(); i++) begin
            if (i == abort_at) begin
                repeat (CPB) @(negedge CLK);
                rst_n = 1'b0;
                @(negedge CLK);
                check("reset_mid_frame_outputs",
                      {imem_we, imem_addr, imem_wd, prog_active, load_done, load_err}, '0);
                rst_n = 1'b1;
                break;
            end
            if (i == ferr_at) begin
                send_byte(fr[i], 1'b0);
                break;
            end
            send_byte(fr[i], 1'b1);
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, CPB)) @(negedge CLK);
        end
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge CLK);
    endtask

    // Monitor: pops the scoreboard on every write strobe and every new status.
    logic we_prev   = 1'b0;
    logic stat_prev = 1'b0;
    wr_t  mon_e;
    logic [1:0] mon_s;
    always @(negedge CLK) begin
        if (rst_n) begin
            if (imem_we) begin
                check("write_strobe_single_cycle", {63'd0, we_prev}, 64'd0);
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h wd %h, required no write",
                             imem_addr, imem_wd);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("write_addr", {32'd0, imem_addr}, {32'd0, mon_e.addr});
                    check("write_data", {32'd0, imem_wd}, {32'd0, mon_e.wd});
                    check("prog_active_during_write", {63'd0, prog_active}, 64'd1);
                end
            end
            if ((load_done || load_err) && !stat_prev) begin
                if (exp_st.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_status: got done %b err %b, required none",
                             load_done, load_err);
                end else begin
                    mon_s = exp_st.pop_front();
                    check("frame_status", {62'd0, load_done, load_err}, {62'd0, mon_s});
                    check("prog_active_released", {63'd0, prog_active}, 64'd0);
                end
            end
        end
        we_prev   <= imem_we;
        stat_prev <= load_done || load_err;
    end

    initial begin
        bq_t         fr;
        logic [31:0] wq[$];
        int          n;

        rst_n = 1'b0;
        repeat (5) @(negedge CLK);
        check("reset_outputs",
              {imem_we, imem_addr, imem_wd, prog_active, load_done, load_err}, '0);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge CLK);
        check("idle_after_reset", {61'd0, prog_active, load_done, load_err}, 64'd0);

        // Single word
        wq = {32'h00100093};
        build_frame(wq, 1'b0, fr);
        run_frame(fr, -1, -1, 1'b0);

        // Two words
        wq = {32'h00100093, 32'h80000337};
        build_frame(wq, 1'b0, fr);
        run_frame(fr, -1, -1, 1'b0);

        // Count just above depth, then count zero, each followed by a good frame
        fr = {8'hA5, 8'h0F};
        run_frame(fr, -1, -1, 1'b0);
        wq = {$urandom()};
        build_frame(wq, 1'b0, fr);
        run_frame(fr, -1, -1, 1'b0);
        fr = {8'hA5, 8'h00};
        run_frame(fr, -1, -1, 1'b0);

        // Bad checksum: word still written
        wq = {32'hDEADBEEF};
        build_frame(wq, 1'b1, fr);
        run_frame(fr, -1, -1, 1'b0);

        // Framing error on 2nd data byte, then idle noise
        wq = {32'h11223344, 32'h55667788};
        build_frame(wq, 1'b0, fr);
        run_frame(fr, 3, -1, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (2 * CPB) @(negedge CLK);
        check("noise_in_idle_ignored", {61'd0, prog_active, load_done, load_err}, 64'd1);

        // Reset during the second word, then a clean frame
        wq = {32'hCAFEF00D, 32'h0BADC0DE};
        build_frame(wq, 1'b0, fr);
        run_frame(fr, -1, 7, 1'b0);
        repeat (3 * CPB) @(negedge CLK);
        wq = {32'h12345678};
        build_frame(wq, 1'b0, fr);
        run_frame(fr, -1, -1, 1'b0);

        // Full depth
        wq = {};
        for (int i = 0; i < MAXW; i++) wq.push_back($urandom());
        build_frame(wq, 1'b0, fr);
        run_frame(fr, -1, -1, 1'b1);

        // Random frames, some with corrupted checksum
        for (int f = 0; f < 8; f++) begin
            wq = {};
            n  = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) wq.push_back($urandom());
            build_frame(wq, ($urandom_range(0, 3) == 0), fr);
            run_frame(fr, -1, -1, 1'b1);
        end

        repeat (4 * CPB) @(negedge CLK);
        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        check("pending_status", 64'(exp_st.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
